// File: rtl/loba_sched.sv
// loba1: combinational leading-one-based approximate multiplier (zero latency, no backpressure).
// Each operand is cut to the K-bit segment under its leading one; the segment product is shifted back.
module loba1 #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    localparam int SW = $clog2(N + 1);

    // Shift that brings the leading one down to bit K-1; operands below 2^K stay exact.
    function automatic logic [SW-1:0] seg_shift(input logic [N-1:0] x);
        logic [SW-1:0] s;
        s = '0;
        for (int i = K; i < N; i++)
            if (x[i]) s = SW'(i - K + 1);
        return s;
    endfunction

    logic [SW-1:0]  sh_a;
    logic [SW-1:0]  sh_b;
    logic [SW:0]    sh_sum;
    logic [K-1:0]   seg_a;
    logic [K-1:0]   seg_b;
    logic [2*K-1:0] seg_p;

    always_comb begin
        sh_a   = seg_shift(a);
        sh_b   = seg_shift(b);
        seg_a  = K'(a >> sh_a);
        seg_b  = K'(b >> sh_b);
        seg_p  = seg_a * seg_b;
        sh_sum = {1'b0, sh_a} + {1'b0, sh_b};
        p      = (2*N)'(seg_p) << sh_sum;
    end
endmodule

// loba_sched: round-robin share of one loba1 among R requesters, 2-cycle latency, 1/cycle throughput.
// Backpressure: a stalled result holds S2, S1 then holds, and req_ready drops to zero.
module loba_sched #(
    parameter int N = 16,
    parameter int K = 4,
    parameter int R = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [R-1:0]         req_valid,
    output logic [R-1:0]         req_ready,
    input  logic [R*N-1:0]       req_a,
    input  logic [R*N-1:0]       req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*N-1:0]       res_p,
    output logic [$clog2(R)-1:0] res_id,
    output logic                 busy
);
    localparam int RW = $clog2(R);

    logic           s1_valid;
    logic [N-1:0]   s1_a;
    logic [N-1:0]   s1_b;
    logic [RW-1:0]  s1_id;
    logic           s2_valid;
    logic [2*N-1:0] s2_p;
    logic [RW-1:0]  s2_id;

    logic [RW-1:0]  ptr;
    logic [RW-1:0]  grant;
    logic [RW-1:0]  ptr_next;
    logic           grant_found;
    logic           adv1;
    logic           adv2;
    logic           accept;
    logic [2*N-1:0] prod;
    int             idx;

    loba1 #(.N(N), .K(K)) u_mul (
        .a (s1_a),
        .b (s1_b),
        .p (prod)
    );

    // Search order ptr, ptr+1, ... wrapping at R, so non-power-of-2 R wraps correctly.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int i = 0; i < R; i++) begin
            idx = int'(ptr) + i;
            if (idx >= R) idx = idx - R;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant       = RW'(idx);
            end
        end
    end

    always_comb begin
        adv2      = !s2_valid || res_ready;
        adv1      = !s1_valid || adv2;
        accept    = grant_found && adv1 && !rst;
        req_ready = accept ? (R'(1) << grant) : '0;
        ptr_next  = (grant == RW'(R - 1)) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_p     <= '0;
            s2_id    <= '0;
            ptr      <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= req_a[int'(grant)*N +: N];
                s1_b     <= req_b[int'(grant)*N +: N];
                s1_id    <= grant;
                ptr      <= ptr_next;
            end else if (adv1) begin
                s1_valid <= 1'b0;
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                s2_p     <= prod;
                s2_id    <= s1_id;
            end
        end
    end

    assign res_valid = s2_valid;
    assign res_p     = s2_p;
    assign res_id    = s2_id;
    assign busy      = s1_valid || s2_valid;
endmodule

// File: tb/tb_loba_sched.sv
// Bench for loba_sched: directed scenarios plus randomized traffic against a behavioural model.
module tb_loba_sched;
    localparam int N = 16;
    localparam int K = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  v4, rdy4;
    logic [63:0] a4, b4;
    logic        rv4, rr4, busy4;
    logic [31:0] p4;
    logic [1:0]  id4;
    logic [2:0]  v3, rdy3;
    logic [47:0] a3, b3;
    logic        rv3, rr3, busy3;
    logic [31:0] p3;
    logic [1:0]  id3;

    int tests;
    int fails;

    loba_sched #(.N(N), .K(K), .R(4)) dut (
        .clk(clk), .rst(rst), .req_valid(v4), .req_ready(rdy4), .req_a(a4), .req_b(b4),
        .res_valid(rv4), .res_ready(rr4), .res_p(p4), .res_id(id4), .busy(busy4)
    );

    loba_sched #(.N(N), .K(K), .R(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_a(a3), .req_b(b3),
        .res_valid(rv3), .res_ready(rr3), .res_p(p3), .res_id(id3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    // Behavioural model of the R=4 instance: two slots, rotating-priority grant.
    int          m_ptr, m_s1id, m_s2id, m_acc;
    bit          m_s1v, m_s2v;
    int unsigned m_s1a, m_s1b;
    logic [31:0] m_s2p;

    // Shrink each operand until it fits in K bits, multiply, scale back.
    function automatic logic [31:0] loba_ref(int unsigned a, int unsigned b);
        int unsigned sa, sb;
        longint unsigned t;
        sa = 0;
        sb = 0;
        while ((a >> sa) >= (1 << K)) sa++;
        while ((b >> sb) >= (1 << K)) sb++;
        t = longint'((a >> sa) * (b >> sb));
        return 32'(t << (sa + sb));
    endfunction

    function automatic int m_grant();
        int r;
        for (int i = 0; i < 4; i++) begin
            r = (m_ptr + i) % 4;
            if (v4[r]) return r;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_ready();
        int g;
        g = m_grant();
        if (rst || g < 0) return 4'b0000;
        if (m_s1v && m_s2v && !rr4) return 4'b0000;
        return 4'(1 << g);
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_s1id = 0; m_s2id = 0;
        m_s1v = 0; m_s2v = 0; m_s1a = 0; m_s1b = 0; m_s2p = '0;
    endtask

    task automatic model_tick();
        int g;
        bit stall, adv2;
        g     = m_grant();
        stall = m_s1v && m_s2v && !rr4;
        adv2  = !m_s2v || rr4;
        if (adv2) begin
            m_s2v  = m_s1v;
            m_s2p  = loba_ref(m_s1a, m_s1b);
            m_s2id = m_s1id;
        end
        if (!stall) begin
            if (g >= 0) begin
                m_s1v  = 1;
                m_s1a  = int'(a4[g*16 +: 16]);
                m_s1b  = int'(b4[g*16 +: 16]);
                m_s1id = g;
                m_ptr  = (g + 1) % 4;
                m_acc++;
            end else begin
                m_s1v = 0;
            end
        end
    endtask

    task automatic tick();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(int r, logic [15:0] a, logic [15:0] b);
        a4[r*16 +: 16] = a;
        b4[r*16 +: 16] = b;
    endtask

    function automatic logic [15:0] rand_op();
        case ($urandom % 4)
            0:       return 16'($urandom_range(0, 15));
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        v4 = '0; v3 = '0; rr4 = 1'b1; rr3 = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v4 = 4'b1111; v3 = 3'b111; rr4 = 1'b1; rr3 = 1'b1;
        a4 = {$urandom, $urandom}; b4 = {$urandom, $urandom};
        a3 = '0; b3 = '0;
        model_reset();
        #1;
        @(posedge clk);
        #1;
        tests += 8;
        if (rdy4 !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b want 0000", rdy4); end
        if (rv4 !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %b want 0", rv4); end
        if (p4 !== 32'd0) begin fails++; $display("FAIL reset_res_p: got %h want 0", p4); end
        if (id4 !== 2'd0) begin fails++; $display("FAIL reset_res_id: got %0d want 0", id4); end
        if (busy4 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy4); end
        if (rdy3 !== 3'b000) begin fails++; $display("FAIL reset_req_ready_r3: got %b want 000", rdy3); end
        if (rv3 !== 1'b0) begin fails++; $display("FAIL reset_res_valid_r3: got %b want 0", rv3); end
        if (busy3 !== 1'b0) begin fails++; $display("FAIL reset_busy_r3: got %b want 0", busy3); end
        v4 = '0; v3 = '0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        v4 = 4'b0100;
        set_op(2, 16'd3, 16'd5);
        #1;
        tests++;
        if (rdy4 !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b want 0100", rdy4); end
        tick();
        v4 = 4'b0000;
        #1;
        tests += 2;
        if (busy4 !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", busy4); end
        if (rv4 !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %b want 0", rv4); end
        tick();
        tests += 3;
        if (rv4 !== 1'b1) begin fails++; $display("FAIL single_res_valid: got %b want 1", rv4); end
        if (p4 !== 32'd15) begin fails++; $display("FAIL single_res_p: got %0d want 15", p4); end
        if (id4 !== 2'd2) begin fails++; $display("FAIL single_res_id: got %0d want 2", id4); end
        tick();
        tests++;
        if (busy4 !== 1'b0) begin fails++; $display("FAIL single_idle: got %b want 0", busy4); end
    endtask

    task automatic test_zero();
        v4 = 4'b0001;
        set_op(0, 16'h0000, 16'h1234);
        #1;
        tick();
        v4 = 4'b0000;
        #1;
        tick();
        tests += 3;
        if (rv4 !== 1'b1) begin fails++; $display("FAIL zero_valid: got %b want 1", rv4); end
        if (p4 !== 32'd0) begin fails++; $display("FAIL zero_res_p: got %h want 0", p4); end
        if (id4 !== 2'd0) begin fails++; $display("FAIL zero_res_id: got %0d want 0", id4); end
        tick();
    endtask

    task automatic test_fairness();
        int nres;
        do_reset();
        nres = 0;
        for (int r = 0; r < 4; r++) set_op(r, 16'hFFFF, rand_op());
        v4 = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            if (c == 12) v4 = 4'b0000;
            #1;
            tests += 5;
            if (c < 12 && rdy4 !== 4'(1 << (c % 4))) begin
                fails++; $display("FAIL fair_grant cyc %0d: got %b want %b", c, rdy4, 4'(1 << (c % 4)));
            end else if (rdy4 !== m_ready()) begin
                fails++; $display("FAIL fair_ready cyc %0d: got %b want %b", c, rdy4, m_ready());
            end
            if (rv4 !== m_s2v) begin fails++; $display("FAIL fair_valid cyc %0d: got %b want %b", c, rv4, m_s2v); end
            if (p4 !== m_s2p) begin fails++; $display("FAIL fair_res_p cyc %0d: got %h want %h", c, p4, m_s2p); end
            if (id4 !== 2'(m_s2id)) begin fails++; $display("FAIL fair_res_id cyc %0d: got %0d want %0d", c, id4, m_s2id); end
            if (c >= 2 && c < 14 && id4 !== 2'((c - 2) % 4)) begin
                fails++; $display("FAIL fair_order cyc %0d: got %0d want %0d", c, id4, (c - 2) % 4);
            end
            if (rv4 === 1'b1) nres++;
            tick();
            if (c < 12) set_op(c % 4, rand_op(), rand_op());
        end
        tests++;
        if (nres !== 12) begin fails++; $display("FAIL fair_count: got %0d results want 12", nres); end
    endtask

    task automatic test_backpressure();
        int acc0, nres, g;
        logic [31:0] p_hold;
        logic [1:0]  id_hold;
        acc0 = m_acc;
        nres = 0;
        for (int r = 0; r < 4; r++) set_op(r, rand_op(), rand_op());
        v4 = 4'b1111;
        rr4 = 1'b1;
        p_hold = '0;
        id_hold = '0;
        for (int c = 0; c < 16; c++) begin
            rr4 = !(c >= 2 && c < 7);
            if (c == 10) v4 = 4'b0000;
            #1;
            if (c == 2) begin p_hold = p4; id_hold = id4; end
            tests += 5;
            if (rdy4 !== m_ready()) begin fails++; $display("FAIL bp_ready cyc %0d: got %b want %b", c, rdy4, m_ready()); end
            if (rv4 !== m_s2v) begin fails++; $display("FAIL bp_valid cyc %0d: got %b want %b", c, rv4, m_s2v); end
            if (p4 !== m_s2p) begin fails++; $display("FAIL bp_res_p cyc %0d: got %h want %h", c, p4, m_s2p); end
            if (id4 !== 2'(m_s2id)) begin fails++; $display("FAIL bp_res_id cyc %0d: got %0d want %0d", c, id4, m_s2id); end
            if (busy4 !== (m_s1v | m_s2v)) begin fails++; $display("FAIL bp_busy cyc %0d: got %b want %b", c, busy4, m_s1v | m_s2v); end
            if (c >= 2 && c < 7) begin
                tests += 4;
                if (rdy4 !== 4'b0000) begin fails++; $display("FAIL bp_stall_ready cyc %0d: got %b want 0000", c, rdy4); end
                if (busy4 !== 1'b1) begin fails++; $display("FAIL bp_stall_busy cyc %0d: got %b want 1", c, busy4); end
                if (p4 !== p_hold) begin fails++; $display("FAIL bp_hold_p cyc %0d: got %h want %h", c, p4, p_hold); end
                if (id4 !== id_hold) begin fails++; $display("FAIL bp_hold_id cyc %0d: got %0d want %0d", c, id4, id_hold); end
            end
            if (rv4 === 1'b1 && rr4) nres++;
            g = (m_ready() != 0) ? m_grant() : -1;
            tick();
            if (g >= 0) set_op(g, rand_op(), rand_op());
        end
        tests++;
        if (nres !== m_acc - acc0) begin fails++; $display("FAIL bp_count: got %0d results want %0d", nres, m_acc - acc0); end
    endtask

    task automatic test_wrap();
        do_reset();
        v4 = 4'b0100; set_op(2, 16'd2, 16'd2);
        v3 = 3'b010; a3[16 +: 16] = 16'd7; b3[16 +: 16] = 16'd9;
        #1;
        tests += 2;
        if (rdy4 !== 4'b0100) begin fails++; $display("FAIL wrap_pre: got %b want 0100", rdy4); end
        if (rdy3 !== 3'b010) begin fails++; $display("FAIL wrap3_pre: got %b want 010", rdy3); end
        tick();
        v4 = 4'b1010; set_op(1, 16'd4, 16'd4); set_op(3, 16'd6, 16'd6);
        v3 = 3'b111;
        #1;
        tests += 2;
        if (rdy4 !== 4'b1000) begin fails++; $display("FAIL wrap_grant3: got %b want 1000", rdy4); end
        if (rdy3 !== 3'b100) begin fails++; $display("FAIL wrap3_grant2: got %b want 100", rdy3); end
        tick();
        v4 = 4'b0010;
        v3 = 3'b011;
        #1;
        tests += 6;
        if (rdy4 !== 4'b0010) begin fails++; $display("FAIL wrap_grant1: got %b want 0010", rdy4); end
        if (rdy3 !== 3'b001) begin fails++; $display("FAIL wrap3_grant0: got %b want 001", rdy3); end
        if (rv3 !== 1'b1) begin fails++; $display("FAIL wrap3_valid: got %b want 1", rv3); end
        if (id3 !== 2'd1) begin fails++; $display("FAIL wrap3_id: got %0d want 1", id3); end
        if (p3 !== 32'd63) begin fails++; $display("FAIL wrap3_p: got %0d want 63", p3); end
        if (p4 !== 32'd4) begin fails++; $display("FAIL wrap_p: got %0d want 4", p4); end
        tick();
        v4 = 4'b0000;
        v3 = 3'b000;
        repeat (3) tick();
    endtask

    task automatic test_rst_midflight();
        for (int r = 0; r < 4; r++) set_op(r, rand_op(), rand_op());
        v4 = 4'b1111;
        rr4 = 1'b0;
        #1;
        tick();
        tick();
        tests += 2;
        if (busy4 !== 1'b1) begin fails++; $display("FAIL mid_full_busy: got %b want 1", busy4); end
        if (rv4 !== 1'b1) begin fails++; $display("FAIL mid_full_valid: got %b want 1", rv4); end
        rst = 1'b1;
        #1;
        model_reset();
        tests += 3;
        if (rv4 !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b want 0", rv4); end
        if (busy4 !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b want 0", busy4); end
        if (rdy4 !== 4'b0000) begin fails++; $display("FAIL mid_rst_ready: got %b want 0000", rdy4); end
        @(posedge clk);
        #1 rst = 1'b0;
        v4 = 4'b0110;
        rr4 = 1'b1;
        #1;
        tests++;
        if (rdy4 !== 4'b0010) begin fails++; $display("FAIL mid_first_grant: got %b want 0010", rdy4); end
        tick();
        v4 = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests += 3;
            if (rv4 !== m_s2v) begin fails++; $display("FAIL mid_drain_valid cyc %0d: got %b want %b", c, rv4, m_s2v); end
            if (p4 !== m_s2p) begin fails++; $display("FAIL mid_drain_p cyc %0d: got %h want %h", c, p4, m_s2p); end
            if (id4 !== 2'(m_s2id)) begin fails++; $display("FAIL mid_drain_id cyc %0d: got %0d want %0d", c, id4, m_s2id); end
            tick();
        end
    endtask

    task automatic test_random();
        int acc0, nres, g;
        do_reset();
        acc0 = m_acc;
        nres = 0;
        for (int c = 0; c < 320; c++) begin
            rr4 = (c >= 300) || ($urandom % 4 != 0);
            #1;
            tests += 5;
            if (rdy4 !== m_ready()) begin fails++; $display("FAIL rnd_ready cyc %0d: got %b want %b", c, rdy4, m_ready()); end
            if (rv4 !== m_s2v) begin fails++; $display("FAIL rnd_valid cyc %0d: got %b want %b", c, rv4, m_s2v); end
            if (p4 !== m_s2p) begin fails++; $display("FAIL rnd_res_p cyc %0d: got %h want %h", c, p4, m_s2p); end
            if (id4 !== 2'(m_s2id)) begin fails++; $display("FAIL rnd_res_id cyc %0d: got %0d want %0d", c, id4, m_s2id); end
            if (busy4 !== (m_s1v | m_s2v)) begin fails++; $display("FAIL rnd_busy cyc %0d: got %b want %b", c, busy4, m_s1v | m_s2v); end
            if (rv4 === 1'b1 && rr4) nres++;
            g = (m_ready() != 0) ? m_grant() : -1;
            tick();
            if (g >= 0) v4[g] = 1'b0;
            for (int r = 0; r < 4; r++) begin
                if (c < 295 && !v4[r] && ($urandom % 3 == 0)) begin
                    v4[r] = 1'b1;
                    set_op(r, rand_op(), rand_op());
                end
            end
        end
        tests++;
        if (nres !== m_acc - acc0) begin fails++; $display("FAIL rnd_count: got %0d results want %0d", nres, m_acc - acc0); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        m_acc = 0;
        rst = 1'b0;
        v4 = '0; v3 = '0; a4 = '0; b4 = '0; a3 = '0; b3 = '0;
        rr4 = 1'b1; rr3 = 1'b1;
        model_reset();
        test_reset();
        test_single();
        test_zero();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_rst_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/loba_sched.md
# loba_sched

Round-robin scheduler that shares one combinational `loba1` approximate multiplier (LOBA, N-bit operands, K-bit leading-one segments) between R requesters. It sits between several datapath clients and the single multiplier instance. Each accepted operand pair is registered, multiplied, registered again, and returned on a common result port tagged with the requester index. The block gives single-cycle throughput, 2-cycle latency and full backpressure.

## Interface
- `N`, default 16: operand width; product width is 2N.
- `K`, default 4: LOBA segment width, passed unchanged to the internal `loba1`.
- `R`, default 4: number of requesters, R ≥ 2; `RW` = clog2(R) (localparam).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input R: bit r means requester r presents operands.
- `req_ready` output R: one-hot or zero; bit r means requester r's operands are taken this cycle.
- `req_a` input R*N: operand A; requester r occupies bits [r*N +: N].
- `req_b` input R*N: operand B, same packing as `req_a`.
- `res_valid` output 1: result present.
- `res_ready` input 1: consumer accepts the result.
- `res_p` output 2N: `loba1` product.
- `res_id` output RW: index of the requester that issued the product.
- `busy` output 1: any pipeline stage is occupied.

## Operation
- Two register stages:
  - S1 holds `s1_valid`, `s1_a`, `s1_b`, `s1_id`.
  - S2 holds `s2_valid`, `s2_p`, `s2_id`.
  - `loba1` sits combinationally between S1 and S2: `s2_p` ← `loba1(s1_a, s1_b)`.
- Advance conditions:
  - `adv2` = !`s2_valid` | `res_ready`.
  - `adv1` = !`s1_valid` | `adv2`.
- Arbitration:
  - `ptr` is an RW-bit round-robin pointer.
  - The grant goes to the first r with `req_valid[r]` = 1, searching `ptr`, `ptr`+1, …, R−1, 0, …, `ptr`−1.
  - `req_ready[g]` = `adv1` & `req_valid[g]` for the granted g. All other bits are 0.
  - `req_ready` is combinational from `req_valid`, `ptr` and pipeline state.
- Accept occurs when `req_valid[g]` & `req_ready[g]`:
  - S1 ← {1, `a[g]`, `b[g]`, g}.
  - `ptr` ← (g+1) mod R. Wrap from R−1 to 0 is required, and must also hold for non-power-of-2 R.
- When `adv1` is true and there is no accept: `s1_valid` ← 0.
- When `adv2` is true: S2 ← {`s1_valid`, `loba1(s1_a, s1_b)`, `s1_id`}.
  - S1 data loads only on accept and S2 data only when `adv2`, so registered values are stable under stall.
- Outputs:
  - `res_valid` = `s2_valid`, `res_p` = `s2_p`, `res_id` = `s2_id`.
  - `busy` = `s1_valid` | `s2_valid`.
- `ptr` does not move when no request is accepted, including when stalled with valid requests pending.
- Requesters must hold `req_valid` and operands stable until their `req_ready` is high. Withdrawal before that is a protocol violation with undefined behaviour.

## Timing
- Reset (async assert, released synchronously by the environment) clears:
  - `s1_valid`, `s2_valid` → 0; `ptr` → 0; all data/id registers → 0.
  - Outputs: `res_valid` 0, `res_p` 0, `res_id` 0, `busy` 0, `req_ready` all 0.
- Reset mid-operation discards in-flight S1/S2 contents. No result is emitted for them.
- Latency: accept at edge t → `res_valid` from edge t+2, provided `res_ready` was high, or S2 was empty, at edge t+1.
- Throughput: one accept per cycle while `res_ready` = 1. Back-to-back results carry consecutive ids under full load.
- Full pipeline (both stages valid) with `res_ready` = 0: `req_ready` = 0 and all stages hold.
- Simultaneous result drain and accept in the same cycle is legal and loses no slot.
- Result order equals accept order (strict FIFO). No reordering.
- Fairness: with all R requesters continuously valid and no stall, each is granted exactly once in every R consecutive cycles.

## Test plan
- **Reset and single request:** after reset, check all outputs are 0. Drive requester 2 with A=3, B=5 → `req_ready` = 4'b0100 in the first cycle, then 2 cycles later `res_valid` = 1, `res_p` = 15, `res_id` = 2. Operands below 2^K are exact.
- **Full-load fairness:** R=4, all valid, `res_ready` = 1 for 12 cycles → grant sequence 0,1,2,3,0,1,2,3,…; 12 results in the same order. Each `res_p` matches a `loba1` model for its operands (e.g. A=B=16'hFFFF).
- **Backpressure:** fill the pipeline, then hold `res_ready` = 0 for 5 cycles → `req_ready` = 0. `res_p`/`res_id` stay stable, `busy` = 1. On release, no duplicated or lost results.
- **Pointer wrap and skip:** `ptr` = 3 with only requesters 1 and 3 valid → grant 3, then `ptr` = 0 → grant 1. Repeat with R=3 to check the wrap from 2 to 0.
- **Reset mid-flight:** assert `rst` with both stages valid → `res_valid`/`busy` drop immediately, before the next clock edge, and `ptr` = 0. After release, the first grant goes to the lowest valid index.
- **Zero operand:** A=0, B=16'h1234 → `res_p` = 0.
